// File: rtl/debug_host_link.sv
// Host-side debug link: streams a program to the target over UART, selects run mode,
// then collects PC/register/memory dumps returned by the target as 32-bit words.
//
// state     | meaning
// IDLE      | waiting for the first program word
// LOAD      | sending program words; an all-zero word ends the program
// MODE_WAIT | program loaded, waiting for debug or continuous run request
// SEND_CMD  | mode/step command byte in flight
// READY     | debug mode, waiting for a step request
// RECV_DUMP | assembling dump words from received bytes
// DONE      | continuous run finished, held until reset
module debug_host_link #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_WIDTH_UART = 8,
  parameter int N_REGS = 32,
  parameter int N_MEM = 32,
  parameter logic [DATA_WIDTH_UART-1:0] CMD_DEBUG = 8'hFF,
  parameter logic [DATA_WIDTH_UART-1:0] CMD_RUN = 8'h55,
  parameter logic [DATA_WIDTH_UART-1:0] CMD_STEP = 8'hAA
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_prog_valid,
  input  logic [DATA_WIDTH-1:0]      i_prog_word,
  output logic                       o_prog_ready,
  input  logic                       i_run_debug,
  input  logic                       i_run_cont,
  input  logic                       i_step,
  output logic                       o_tx_signal,
  output logic [DATA_WIDTH_UART-1:0] o_tx_result,
  input  logic                       i_tx_done,
  input  logic                       i_rx_done,
  input  logic [DATA_WIDTH_UART-1:0] i_rx_data,
  output logic [DATA_WIDTH-1:0]      o_word,
  output logic                       o_word_valid,
  output logic [1:0]                 o_word_sel,
  output logic [5:0]                 o_word_idx,
  output logic                       o_dump_done,
  output logic                       o_busy,
  output logic                       o_rx_err
);

  localparam int BPW = DATA_WIDTH / DATA_WIDTH_UART;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TOTAL = 1 + N_REGS + N_MEM;
  localparam int WCW = $clog2(TOTAL + 1);
  localparam logic [DATA_WIDTH-DATA_WIDTH_UART-1:0] PAD = '0;

  typedef enum logic [2:0] {
    IDLE, LOAD, MODE_WAIT, SEND_CMD, READY, RECV_DUMP, DONE
  } state_t;

  state_t state, state_next;

  logic                              tx_active;
  logic [BCW-1:0]                    tx_left;
  logic [DATA_WIDTH-1:0]             tx_shift;
  logic                              tx_start;
  logic [DATA_WIDTH-1:0]             tx_data;
  logic [BCW-1:0]                    tx_count;
  logic                              word_zero;
  logic                              mode_debug;
  logic                              cmd_to_dump;
  logic [BCW-1:0]                    rx_byte_cnt;
  logic [WCW-1:0]                    rx_word_cnt;
  logic [DATA_WIDTH-DATA_WIDTH_UART-1:0] rx_shift;
  logic                              accept;
  logic                              tx_last_done;
  logic                              rx_word_end;
  logic                              dump_end;
  logic [1:0]                        word_sel;
  logic [WCW-1:0]                    word_idx;

  assign o_prog_ready = (state == IDLE || state == LOAD) && !tx_active;
  assign accept       = i_prog_valid && o_prog_ready;
  assign tx_last_done = tx_active && i_tx_done && (tx_left == '0);
  assign rx_word_end  = (state == RECV_DUMP) && i_rx_done && (rx_byte_cnt == BCW'(BPW - 1));
  assign dump_end     = rx_word_end && (rx_word_cnt == WCW'(TOTAL - 1));
  assign o_busy       = !(state == IDLE || state == READY);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    tx_data    = '0;
    tx_count   = '0;
    case (state)
      IDLE, LOAD: begin
        if (accept) begin
          tx_start   = 1'b1;
          tx_data    = i_prog_word;
          tx_count   = BCW'(BPW - 1);
          state_next = LOAD;
        end else if (state == LOAD && tx_last_done && word_zero) begin
          state_next = MODE_WAIT;
        end
      end
      MODE_WAIT: begin
        // debug wins when both requests arrive together
        if (i_run_debug) begin
          tx_start   = 1'b1;
          tx_data    = {CMD_DEBUG, PAD};
          state_next = SEND_CMD;
        end else if (i_run_cont) begin
          tx_start   = 1'b1;
          tx_data    = {CMD_RUN, PAD};
          state_next = SEND_CMD;
        end
      end
      SEND_CMD: begin
        if (tx_last_done) state_next = cmd_to_dump ? RECV_DUMP : READY;
      end
      READY: begin
        if (i_step) begin
          tx_start   = 1'b1;
          tx_data    = {CMD_STEP, PAD};
          state_next = SEND_CMD;
        end
      end
      RECV_DUMP: begin
        if (dump_end) state_next = mode_debug ? READY : DONE;
      end
      DONE: state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      word_zero   <= 1'b0;
      mode_debug  <= 1'b0;
      cmd_to_dump <= 1'b0;
    end else begin
      if (accept) word_zero <= (i_prog_word == '0);
      if (state == MODE_WAIT && (i_run_debug || i_run_cont)) begin
        mode_debug  <= i_run_debug;
        cmd_to_dump <= !i_run_debug;
      end else if (state == READY && i_step) begin
        cmd_to_dump <= 1'b1;
      end
    end
  end

  // Byte sender: next byte leaves on the cycle after the previous byte's done.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      tx_active   <= 1'b0;
      tx_left     <= '0;
      tx_shift    <= '0;
      o_tx_signal <= 1'b0;
      o_tx_result <= '0;
    end else begin
      o_tx_signal <= 1'b0;
      if (tx_start) begin
        tx_active   <= 1'b1;
        o_tx_signal <= 1'b1;
        o_tx_result <= tx_data[DATA_WIDTH-1 -: DATA_WIDTH_UART];
        tx_shift    <= tx_data << DATA_WIDTH_UART;
        tx_left     <= tx_count;
      end else if (tx_active && i_tx_done) begin
        if (tx_left != '0) begin
          o_tx_signal <= 1'b1;
          o_tx_result <= tx_shift[DATA_WIDTH-1 -: DATA_WIDTH_UART];
          tx_shift    <= tx_shift << DATA_WIDTH_UART;
          tx_left     <= tx_left - 1'b1;
        end else begin
          tx_active <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    word_sel = 2'd0;
    word_idx = '0;
    if (rx_word_cnt == '0) begin
      word_sel = 2'd0;
    end else if (rx_word_cnt <= WCW'(N_REGS)) begin
      word_sel = 2'd1;
      word_idx = rx_word_cnt - WCW'(1);
    end else begin
      word_sel = 2'd2;
      word_idx = rx_word_cnt - WCW'(N_REGS + 1);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rx_byte_cnt  <= '0;
      rx_word_cnt  <= '0;
      rx_shift     <= '0;
      o_word       <= '0;
      o_word_valid <= 1'b0;
      o_word_sel   <= 2'd0;
      o_word_idx   <= 6'd0;
      o_dump_done  <= 1'b0;
      o_rx_err     <= 1'b0;
    end else begin
      o_word_valid <= 1'b0;
      o_dump_done  <= 1'b0;
      if (state != RECV_DUMP && state_next == RECV_DUMP) begin
        rx_byte_cnt <= '0;
        rx_word_cnt <= '0;
      end else if (state == RECV_DUMP && i_rx_done) begin
        rx_shift    <= {rx_shift[DATA_WIDTH-2*DATA_WIDTH_UART-1:0], i_rx_data};
        rx_byte_cnt <= rx_byte_cnt + 1'b1;
        if (rx_word_end) begin
          rx_byte_cnt  <= '0;
          o_word       <= {rx_shift, i_rx_data};
          o_word_valid <= 1'b1;
          o_word_sel   <= word_sel;
          o_word_idx   <= 6'(word_idx);
          o_dump_done  <= dump_end;
          // hold at the last index so the count never wraps inside a dump
          if (!dump_end) rx_word_cnt <= rx_word_cnt + 1'b1;
        end
      end
      if (state != RECV_DUMP && i_rx_done) o_rx_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_debug_host_link.sv
// Directed bench for debug_host_link: program load, debug/step and continuous dumps,
// stray receive, and reset in the middle of a dump.
module tb_debug_host_link;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_prog_valid = 1'b0;
  logic [31:0] i_prog_word = '0;
  logic        o_prog_ready;
  logic        i_run_debug = 1'b0;
  logic        i_run_cont = 1'b0;
  logic        i_step = 1'b0;
  logic        o_tx_signal;
  logic [7:0]  o_tx_result;
  logic        i_tx_done;
  logic        i_rx_done = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic [31:0] o_word;
  logic        o_word_valid;
  logic [1:0]  o_word_sel;
  logic [5:0]  o_word_idx;
  logic        o_dump_done;
  logic        o_busy;
  logic        o_rx_err;

  debug_host_link dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_prog_valid(i_prog_valid), .i_prog_word(i_prog_word), .o_prog_ready(o_prog_ready),
    .i_run_debug(i_run_debug), .i_run_cont(i_run_cont), .i_step(i_step),
    .o_tx_signal(o_tx_signal), .o_tx_result(o_tx_result), .i_tx_done(i_tx_done),
    .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
    .o_word(o_word), .o_word_valid(o_word_valid), .o_word_sel(o_word_sel),
    .o_word_idx(o_word_idx), .o_dump_done(o_dump_done), .o_busy(o_busy), .o_rx_err(o_rx_err)
  );

  always #5 i_clock = ~i_clock;

  int n_cmp = 0;
  int n_fail = 0;
  int sig_cnt = 0;
  int wv_cnt = 0;
  int done_cnt = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] word_log[256];
  logic [1:0]  sel_log[256];
  logic [5:0]  idx_log[256];
  logic [1:0]  done_sel = '0;
  logic [5:0]  done_idx = '0;
  logic        done_valid = 1'b0;

  // UART TX model: acknowledges every started byte two cycles later
  initial begin
    i_tx_done = 1'b0;
    forever begin
      @(negedge i_clock);
      i_tx_done = 1'b0;
      if (o_tx_signal && !i_reset) begin
        tx_q.push_back(o_tx_result);
        repeat (2) @(negedge i_clock);
        i_tx_done = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge i_clock);
    if (o_tx_signal) sig_cnt++;
    if (o_word_valid) begin
      word_log[wv_cnt % 256] = o_word;
      sel_log[wv_cnt % 256]  = o_word_sel;
      idx_log[wv_cnt % 256]  = o_word_idx;
      wv_cnt++;
    end
    if (o_dump_done) begin
      done_cnt++;
      done_sel   = o_word_sel;
      done_idx   = o_word_idx;
      done_valid = o_word_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dump_word(input int w);
    logic [7:0] wb;
    wb = 8'(w);
    if (w == 0) return 32'h80E17021;
    return {8'hA0, wb, 8'h5A, ~wb};
  endfunction

  task automatic load_word(input logic [31:0] w);
    for (int i = 0; i < 200 && !o_prog_ready; i++) @(negedge i_clock);
    chk("prog_ready_before_load", o_prog_ready, 1);
    i_prog_valid = 1'b1;
    i_prog_word  = w;
    @(negedge i_clock);
    i_prog_valid = 1'b0;
    i_prog_word  = '0;
  endtask

  task automatic wait_tx(input int n);
    for (int i = 0; i < 400 && tx_q.size() < n; i++) @(negedge i_clock);
    chk("tx_byte_count", tx_q.size(), n);
  endtask

  task automatic send_rx(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(negedge i_clock);
    i_rx_done = 1'b0;
    @(negedge i_clock);
  endtask

  task automatic send_dump(input int nbytes);
    logic [31:0] w;
    for (int k = 0; k < nbytes; k++) begin
      w = dump_word(k / 4);
      send_rx(w[31 - 8 * (k % 4) -: 8]);
    end
  endtask

  task automatic pulse_cmd(input logic dbg, input logic cont, input logic stp);
    i_run_debug = dbg;
    i_run_cont  = cont;
    i_step      = stp;
    @(negedge i_clock);
    i_run_debug = 1'b0;
    i_run_cont  = 1'b0;
    i_step      = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_a[8];
    logic [7:0] exp_b[8];
    int s;
    exp_a = '{8'hFF, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'h00, 8'h00};

    repeat (2) @(negedge i_clock);
    chk("rst_tx_signal", o_tx_signal, 0);
    chk("rst_word_valid", o_word_valid, 0);
    chk("rst_dump_done", o_dump_done, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_rx_err", o_rx_err, 0);
    chk("rst_word", o_word, 0);
    chk("rst_tx_result", o_tx_result, 0);
    i_reset = 1'b0;
    @(negedge i_clock);
    chk("rst_prog_ready", o_prog_ready, 1);

    load_word(32'hFF020304);
    load_word(32'h00000000);
    wait_tx(8);
    repeat (4) @(negedge i_clock);
    for (int i = 0; i < 8; i++) chk($sformatf("prog_byte_%0d", i), tx_q[i], exp_a[i]);
    chk("mode_wait_busy", o_busy, 1);
    chk("mode_wait_ready", o_prog_ready, 0);

    s = sig_cnt;
    i_prog_valid = 1'b1;
    i_prog_word  = 32'h11111111;
    repeat (3) @(negedge i_clock);
    i_prog_valid = 1'b0;
    i_prog_word  = '0;
    chk("prog_ignored_no_tx", sig_cnt, s);

    pulse_cmd(1'b1, 1'b1, 1'b0);
    wait_tx(9);
    repeat (4) @(negedge i_clock);
    chk("cmd_debug_byte", tx_q[8], 8'hFF);
    chk("ready_busy", o_busy, 0);
    chk("ready_prog_ready", o_prog_ready, 0);

    send_rx(8'h12);
    repeat (2) @(negedge i_clock);
    chk("stray_rx_err", o_rx_err, 1);
    chk("stray_no_word", wv_cnt, 0);

    pulse_cmd(1'b0, 1'b0, 1'b1);
    wait_tx(10);
    repeat (4) @(negedge i_clock);
    chk("cmd_step_byte", tx_q[9], 8'hAA);
    chk("recv_busy", o_busy, 1);

    send_dump(260);
    repeat (3) @(negedge i_clock);
    chk("dbg_word_count", wv_cnt, 65);
    chk("pc_word", word_log[0], 32'h80E17021);
    chk("pc_sel", sel_log[0], 0);
    chk("pc_idx", idx_log[0], 0);
    chk("reg5_word", word_log[6], 32'hA0065AF9);
    chk("reg5_sel", sel_log[6], 1);
    chk("reg5_idx", idx_log[6], 5);
    chk("mem0_word", word_log[33], 32'hA0215ADE);
    chk("mem0_sel", sel_log[33], 2);
    chk("mem0_idx", idx_log[33], 0);
    chk("mem31_word", word_log[64], 32'hA0405ABF);
    chk("mem31_idx", idx_log[64], 31);
    chk("dbg_done_count", done_cnt, 1);
    chk("dbg_done_sel", done_sel, 2);
    chk("dbg_done_idx", done_idx, 31);
    chk("dbg_done_with_valid", done_valid, 1);
    chk("dbg_back_to_ready", o_busy, 0);
    chk("dbg_tx_pulses", sig_cnt, 10);

    pulse_cmd(1'b0, 1'b0, 1'b1);
    wait_tx(11);
    repeat (4) @(negedge i_clock);
    chk("step2_byte", tx_q[10], 8'hAA);
    send_dump(100);
    i_reset = 1'b1;
    @(negedge i_clock);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_rx_err", o_rx_err, 0);
    chk("mid_rst_word", o_word, 0);
    chk("mid_rst_tx_result", o_tx_result, 0);
    chk("mid_rst_word_valid", o_word_valid, 0);
    chk("mid_rst_tx_signal", o_tx_signal, 0);
    chk("mid_rst_dump_done", o_dump_done, 0);
    chk("mid_rst_words_seen", wv_cnt, 90);
    s = sig_cnt;
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
    repeat (5) @(negedge i_clock);
    chk("mid_rst_no_tx", sig_cnt, s);
    chk("mid_rst_prog_ready", o_prog_ready, 1);

    tx_q.delete();
    load_word(32'h12345678);
    load_word(32'h00000000);
    wait_tx(8);
    repeat (4) @(negedge i_clock);
    for (int i = 0; i < 8; i++) chk($sformatf("reload_byte_%0d", i), tx_q[i], exp_b[i]);
    chk("reload_mode_wait", o_busy, 1);

    pulse_cmd(1'b0, 1'b1, 1'b0);
    wait_tx(9);
    repeat (4) @(negedge i_clock);
    chk("cmd_run_byte", tx_q[8], 8'h55);
    chk("cont_recv_busy", o_busy, 1);

    send_dump(260);
    repeat (3) @(negedge i_clock);
    chk("cont_word_count", wv_cnt, 155);
    chk("cont_done_count", done_cnt, 2);
    chk("cont_done_idx", done_idx, 31);
    chk("done_busy", o_busy, 1);
    chk("done_prog_ready", o_prog_ready, 0);

    s = sig_cnt;
    pulse_cmd(1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge i_clock);
    chk("done_step_no_tx", sig_cnt, s);
    chk("done_persists", o_busy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_host_link.md
DEBUG_HOST_LINK -- requirements
Module: debug_host_link

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- DATA_WIDTH, 32, word width.
- DATA_WIDTH_UART, 8, UART byte width.
- N_REGS, 32, register words per dump.
- N_MEM, 32, memory words per dump.
- CMD_DEBUG, 8'hFF, debug-mode command byte.
- CMD_RUN, 8'h55, continuous-mode command byte.
- CMD_STEP, 8'hAA, single-step command byte.
REQ-002 SHALL have one clock; reset is asynchronous and active-high. Ports (name, direction, width, meaning):
- i_clock, in, 1, clock.
- i_reset, in, 1, async active-high reset.
- i_prog_valid, in, 1, program word offered.
- i_prog_word, in, DATA_WIDTH, instruction word; all-zero word = end of program.
- o_prog_ready, out, 1, word accepted this cycle.
- i_run_debug, in, 1, pulse: send CMD_DEBUG.
- i_run_cont, in, 1, pulse: send CMD_RUN.
- i_step, in, 1, pulse: send CMD_STEP.
- o_tx_signal, out, 1, one-cycle UART TX start.
- o_tx_result, out, DATA_WIDTH_UART, TX byte.
- i_tx_done, in, 1, UART byte-sent pulse.
- i_rx_done, in, 1, UART byte-received pulse.
- i_rx_data, in, DATA_WIDTH_UART, received byte.
- o_word, out, DATA_WIDTH, assembled dump word.
- o_word_valid, out, 1, one-cycle strobe for o_word.
- o_word_sel, out, 2, 0=PC, 1=register, 2=memory.
- o_word_idx, out, 6, index within section (PC: 0).
- o_dump_done, out, 1, one-cycle pulse after last dump word.
- o_busy, out, 1, high in every state except IDLE and READY.
- o_rx_err, out, 1, sticky: byte received outside RECV_DUMP.

Function
REQ-003 SHALL implement FSM states IDLE, LOAD, MODE_WAIT, SEND_CMD, READY, RECV_DUMP, DONE.
REQ-004 IDLE/LOAD: o_prog_ready SHALL be high only when no byte transmission is in progress; a word SHALL be accepted on i_prog_valid & o_prog_ready.
REQ-005 An accepted word SHALL be sent as 4 bytes, MSB first; each byte: o_tx_signal high exactly 1 cycle with o_tx_result stable until i_tx_done; the next byte SHALL start on the cycle after i_tx_done.
REQ-006 After the 4 bytes of an all-zero word are sent, the FSM SHALL go to MODE_WAIT.
REQ-007 MODE_WAIT: i_run_debug SHALL send CMD_DEBUG, then go to READY; i_run_cont SHALL send CMD_RUN, then go to RECV_DUMP; both asserted together SHALL select debug.
REQ-008 READY: i_step SHALL send CMD_STEP, then go to RECV_DUMP; i_step pulses in other states SHALL be ignored.
REQ-009 RECV_DUMP: the block SHALL expect 4*(1+N_REGS+N_MEM) bytes, assembled MSB first, in section order PC, registers 0..N_REGS-1, memory 0..N_MEM-1.
REQ-010 o_word_valid SHALL pulse on the cycle after the i_rx_done of each 4th byte, with o_word, o_word_sel and o_word_idx valid in that cycle.
REQ-011 After the last word, o_dump_done SHALL pulse together with that word's o_word_valid.
- Next state SHALL be READY after a debug-mode dump.
- Next state SHALL be DONE after a continuous-mode dump.
REQ-012 DONE SHALL persist until reset.
REQ-013 i_rx_done outside RECV_DUMP SHALL set o_rx_err and SHALL discard the byte.
REQ-014 i_tx_done without a pending byte SHALL be ignored; i_prog_valid outside IDLE/LOAD SHALL be ignored.
REQ-015 Byte and word counters SHALL clear on entry to RECV_DUMP and SHALL not wrap within a dump.

Reset
REQ-016 On i_reset, asynchronously:
- state SHALL be IDLE.
- All counters SHALL be cleared.
- o_tx_signal, o_word_valid, o_dump_done, o_busy and o_rx_err SHALL be 0.
- o_word and o_tx_result SHALL be 0.
- o_prog_ready SHALL be 1 after reset release.
REQ-017 Reset during any transfer SHALL abort it with no further o_tx_signal.

Verification
REQ-018 Program words 0xFF020304 and 0x00000000 with a TX model acking each byte -> bytes FF,02,03,04,00,00,00,00 in order; state MODE_WAIT.
REQ-019 i_run_debug then i_step, RX model returns 260 bytes:
- Expected TX bytes: FF, AA.
- Expected output: 65 o_word_valid pulses.
- First o_word = PC (sel 0); o_dump_done on mem idx 31; state READY.
REQ-020 PC bytes 80,E1,70,21 -> o_word=0x80E17021, o_word_sel=0, o_word_idx=0.
REQ-021 i_run_cont, then a 260-byte dump -> TX byte 55, o_dump_done, state DONE; further i_step -> no TX.
REQ-022 i_rx_done pulse in READY -> o_rx_err=1 and no o_word_valid.
REQ-023 Assert i_reset mid-dump (byte 100) -> all outputs at reset values; a new program load then succeeds.
